// File: rtl/tlight_ped_req.sv
// tlight_ped_req: pedestrian button front end with sync, debounce, latched requests
// and per-axis call/urgency flags for the intersection light controller.
`default_nettype none

module tlight_ped_req #(
  parameter int DEB_CYCLES = 4,
  parameter int WAIT_W     = 8,
  parameter int MAX_WAIT   = 200
) (
  input  logic       Cp,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic [3:0] walk_g,
  output logic [3:0] req,
  output logic       ew_call,
  output logic       ns_call,
  output logic       ew_urgent,
  output logic       ns_urgent
);

  localparam int                CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0]     CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [3:0]        sync1;
  logic [3:0]        sync2;
  logic [3:0]        db;
  logic [3:0]        db_d;
  logic [3:0]        press;
  logic [3:0]        req_next;
  logic              ew_call_next;
  logic              ns_call_next;
  logic [WAIT_W-1:0] ew_cnt;
  logic [WAIT_W-1:0] ns_cnt;

  always_ff @(posedge Cp or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db_d  <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      db_d  <= db;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [CW-1:0] cnt;

    // Any return of the synchronised level to the accepted level restarts the count.
    always_ff @(posedge Cp or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        db[i] <= 1'b0;
      end else if (sync2[i] == db[i]) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db[i] <= sync2[i];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press    = db & ~db_d;
  // Walk-green clear dominates a simultaneous press.
  assign req_next = (req | press) & ~walk_g;

  assign ew_call_next = req_next[0] | req_next[1];
  assign ns_call_next = req_next[2] | req_next[3];

  // Counters clear on the same edge the call drops so urgency falls with the call.
  always_ff @(posedge Cp or posedge reset) begin
    if (reset) begin
      req    <= '0;
      ew_cnt <= '0;
      ns_cnt <= '0;
    end else begin
      req <= req_next;

      if (!ew_call_next)
        ew_cnt <= '0;
      else if (ew_call && ew_cnt != WAIT_MAX)
        ew_cnt <= ew_cnt + WAIT_W'(1);

      if (!ns_call_next)
        ns_cnt <= '0;
      else if (ns_call && ns_cnt != WAIT_MAX)
        ns_cnt <= ns_cnt + WAIT_W'(1);
    end
  end

  assign ew_call   = req[0] | req[1];
  assign ns_call   = req[2] | req[3];
  assign ew_urgent = (ew_cnt == WAIT_MAX);
  assign ns_urgent = (ns_cnt == WAIT_MAX);

endmodule

`default_nettype wire

// File: tb/tb_tlight_ped_req.sv
// tb_tlight_ped_req: directed scenario bench for tlight_ped_req (DEB_CYCLES=4, MAX_WAIT=10).
`default_nettype none

module tb_tlight_ped_req;

  logic       Cp;
  logic       reset;
  logic [3:0] btn;
  logic [3:0] walk_g;
  logic [3:0] req;
  logic       ew_call;
  logic       ns_call;
  logic       ew_urgent;
  logic       ns_urgent;

  int errors = 0;
  int checks = 0;

  tlight_ped_req #(
    .DEB_CYCLES(4),
    .WAIT_W    (8),
    .MAX_WAIT  (10)
  ) dut (
    .Cp       (Cp),
    .reset    (reset),
    .btn      (btn),
    .walk_g   (walk_g),
    .req      (req),
    .ew_call  (ew_call),
    .ns_call  (ns_call),
    .ew_urgent(ew_urgent),
    .ns_urgent(ns_urgent)
  );

  initial Cp = 1'b0;
  always #5 Cp = ~Cp;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Cp);
      #1;
    end
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    btn    = 4'b0000;
    walk_g = 4'b0000;
    #1;
    checks++;
    if ({req, ew_call, ns_call, ew_urgent, ns_urgent} !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: outputs=%b expected 00000000",
               {req, ew_call, ns_call, ew_urgent, ns_urgent});
    end
    tick(2);
    checks++;
    if ({req, ew_call, ns_call, ew_urgent, ns_urgent} !== 8'h00) begin
      errors++;
      $display("FAIL reset_clocked: outputs=%b expected 00000000",
               {req, ew_call, ns_call, ew_urgent, ns_urgent});
    end
    reset = 1'b0;
  endtask

  task automatic test_press_latency;
    btn = 4'b0001;
    tick(6);
    checks++;
    if (req !== 4'b0000) begin
      errors++;
      $display("FAIL latency_edge6: req=%b expected 0000", req);
    end
    tick(1);
    checks++;
    if (req !== 4'b0001 || ew_call !== 1'b1 || ns_call !== 1'b0) begin
      errors++;
      $display("FAIL latency_edge7: req=%b ew=%b ns=%b expected 0001 1 0", req, ew_call, ns_call);
    end
  endtask

  task automatic test_urgent;
    tick(9);
    checks++;
    if (ew_urgent !== 1'b0) begin
      errors++;
      $display("FAIL urgent_edge9: ew_urgent=%b expected 0", ew_urgent);
    end
    tick(1);
    checks++;
    if (ew_urgent !== 1'b1 || ns_urgent !== 1'b0) begin
      errors++;
      $display("FAIL urgent_edge10: ew_urgent=%b ns_urgent=%b expected 1 0", ew_urgent, ns_urgent);
    end
    tick(5);
    checks++;
    if (ew_urgent !== 1'b1) begin
      errors++;
      $display("FAIL urgent_saturate: ew_urgent=%b expected 1", ew_urgent);
    end
    btn = 4'b0000;
  endtask

  task automatic test_walk_clear;
    walk_g = 4'b0001;
    tick(1);
    walk_g = 4'b0000;
    checks++;
    if (req !== 4'b0000 || ew_call !== 1'b0 || ew_urgent !== 1'b0) begin
      errors++;
      $display("FAIL walk_clear: req=%b ew=%b ew_urg=%b expected 0000 0 0", req, ew_call, ew_urgent);
    end
    tick(1);
    checks++;
    if (ew_urgent !== 1'b0 || ew_call !== 1'b0) begin
      errors++;
      $display("FAIL walk_clear_hold: ew=%b ew_urg=%b expected 0 0", ew_call, ew_urgent);
    end
  endtask

  task automatic test_bounce;
    tick(8);
    for (int t = 0; t < 4; t++) begin
      btn[2] = ~btn[2];
      tick(2);
      checks++;
      if (req !== 4'b0000) begin
        errors++;
        $display("FAIL bounce_%0d: req=%b expected 0000", t, req);
      end
    end
    btn[2] = 1'b1;
    tick(6);
    checks++;
    if (req[2] !== 1'b0) begin
      errors++;
      $display("FAIL bounce_edge6: req[2]=%b expected 0", req[2]);
    end
    tick(1);
    checks++;
    if (req !== 4'b0100 || ns_call !== 1'b1 || ew_call !== 1'b0) begin
      errors++;
      $display("FAIL bounce_edge7: req=%b ns=%b ew=%b expected 0100 1 0", req, ns_call, ew_call);
    end
  endtask

  task automatic test_walk_block;
    btn[1] = 1'b1;
    tick(4);
    walk_g = 4'b0010;
    tick(3);
    checks++;
    if (req[1] !== 1'b0) begin
      errors++;
      $display("FAIL walk_block_edge7: req[1]=%b expected 0", req[1]);
    end
    tick(1);
    walk_g = 4'b0000;
    tick(10);
    checks++;
    if (req !== 4'b0100 || ew_call !== 1'b0) begin
      errors++;
      $display("FAIL walk_block_after: req=%b ew=%b expected 0100 0", req, ew_call);
    end
    checks++;
    if (ns_urgent !== 1'b1 || ew_urgent !== 1'b0) begin
      errors++;
      $display("FAIL axis_independent: ns_urg=%b ew_urg=%b expected 1 0", ns_urgent, ew_urgent);
    end
  endtask

  task automatic test_all_four;
    btn    = 4'b0000;
    walk_g = 4'b0100;
    tick(1);
    walk_g = 4'b0000;
    checks++;
    if (req !== 4'b0000 || ns_call !== 1'b0 || ns_urgent !== 1'b0) begin
      errors++;
      $display("FAIL ns_clear: req=%b ns=%b ns_urg=%b expected 0000 0 0", req, ns_call, ns_urgent);
    end
    tick(8);
    btn = 4'b1111;
    tick(6);
    checks++;
    if (req !== 4'b0000) begin
      errors++;
      $display("FAIL all4_edge6: req=%b expected 0000", req);
    end
    tick(1);
    checks++;
    if (req !== 4'b1111 || ew_call !== 1'b1 || ns_call !== 1'b1) begin
      errors++;
      $display("FAIL all4_edge7: req=%b ew=%b ns=%b expected 1111 1 1", req, ew_call, ns_call);
    end
    tick(4);
  endtask

  task automatic test_async_reset;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({req, ew_call, ns_call, ew_urgent, ns_urgent} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: outputs=%b expected 00000000",
               {req, ew_call, ns_call, ew_urgent, ns_urgent});
    end
    tick(1);
    reset = 1'b0;
    tick(6);
    checks++;
    if (req !== 4'b0000) begin
      errors++;
      $display("FAIL redebounce_edge6: req=%b expected 0000", req);
    end
    tick(1);
    checks++;
    if (req !== 4'b1111) begin
      errors++;
      $display("FAIL redebounce_edge7: req=%b expected 1111", req);
    end
    tick(10);
    checks++;
    if (ew_urgent !== 1'b1 || ns_urgent !== 1'b1) begin
      errors++;
      $display("FAIL both_urgent: ew_urg=%b ns_urg=%b expected 1 1", ew_urgent, ns_urgent);
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_urgent();
    test_walk_clear();
    test_bounce();
    test_walk_block();
    test_all_four();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
